// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - CPU load/store port bundle between the core and the data-memory responder
interface data_mem_responder_if;
    logic       EN_L;
    logic [7:0] ADDR;
    logic [7:0] WDATA;
    logic       MW;
    logic [7:0] RDATA;

    modport master (
        output EN_L,
        output ADDR,
        output WDATA,
        output MW,
        input  RDATA
    );

    modport slave (
        input  EN_L,
        input  ADDR,
        input  WDATA,
        input  MW,
        output RDATA
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - byte RAM plus memory-mapped OUT/CYC/STC/STATUS registers on the CPU data port
module data_mem_responder #(
    parameter int DEPTH = 64
) (
    input  logic                 CLK,
    input  logic                 RESET_L,
    data_mem_responder_if.slave  bus,
    output logic [7:0]           OUT_PORT,
    output logic                 ERR
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    localparam logic [7:0] ADDR_OUT    = 8'hFC;
    localparam logic [7:0] ADDR_CYC    = 8'hFD;
    localparam logic [7:0] ADDR_STC    = 8'hFE;
    localparam logic [7:0] ADDR_STATUS = 8'hFF;

    logic [7:0] mem [2**AW];

    logic [7:0] out_q;
    logic [7:0] cyc_q;
    logic [7:0] stc_q;
    logic       err_q;
    logic       wrap_q;

    logic       enabled;
    logic       store;
    logic       ram_hit;
    logic       io_hit;
    logic       wr_ram;
    logic       wr_out;
    logic       wr_cyc;
    logic       wr_stc;
    logic       wr_status;
    logic       cyc_inc;
    logic       wrap_evt;
    logic       err_evt;
    logic       err_d;
    logic       wrap_d;
    logic [7:0] stc_d;

    // Address decode; anything between RAM and the I/O block is unmapped.
    assign enabled   = ~bus.EN_L;
    assign store     = bus.MW & enabled;
    assign ram_hit   = {1'b0, bus.ADDR} < DEPTH_W;
    assign io_hit    = bus.ADDR >= ADDR_OUT;

    assign wr_ram    = store & ram_hit;
    assign wr_out    = store & (bus.ADDR == ADDR_OUT);
    assign wr_cyc    = store & (bus.ADDR == ADDR_CYC);
    assign wr_stc    = store & (bus.ADDR == ADDR_STC);
    assign wr_status = store & (bus.ADDR == ADDR_STATUS);
    assign err_evt   = store & ~ram_hit & ~io_hit;

    // A load of CYC replaces the increment, so only a free-running step can wrap.
    assign cyc_inc   = enabled & ~wr_cyc;
    assign wrap_evt  = cyc_inc & (cyc_q == 8'hFF);

    // Status bits: W1C, but a same-cycle event keeps the bit set.
    assign err_d     = err_evt  | (err_q  & ~(wr_status & bus.WDATA[0]));
    assign wrap_d    = wrap_evt | (wrap_q & ~(wr_status & bus.WDATA[1]));

    always_comb begin
        stc_d = stc_q;
        if (wr_stc) begin
            stc_d = 8'h00;
        end else if (store && (stc_q != 8'hFF)) begin
            stc_d = stc_q + 8'd1;
        end
    end

    // RAM content is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_ram) begin
            mem[bus.ADDR[AW-1:0]] <= bus.WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            out_q  <= 8'h00;
            cyc_q  <= 8'h00;
            stc_q  <= 8'h00;
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else if (enabled) begin
            if (wr_out) begin
                out_q <= bus.WDATA;
            end
            if (wr_cyc) begin
                cyc_q <= bus.WDATA;
            end else if (cyc_inc) begin
                cyc_q <= cyc_q + 8'd1;
            end
            stc_q  <= stc_d;
            err_q  <= err_d;
            wrap_q <= wrap_d;
        end
    end

    // Combinational read: the value written on an edge only appears after it.
    always_comb begin
        bus.RDATA = 8'h00;
        if (ram_hit) begin
            bus.RDATA = mem[bus.ADDR[AW-1:0]];
        end else begin
            case (bus.ADDR)
                ADDR_OUT:    bus.RDATA = out_q;
                ADDR_CYC:    bus.RDATA = cyc_q;
                ADDR_STC:    bus.RDATA = stc_q;
                ADDR_STATUS: bus.RDATA = {6'b000000, wrap_q, err_q};
                default:     bus.RDATA = 8'h00;
            endcase
        end
    end

    assign OUT_PORT = out_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench for data_mem_responder against a behavioural memory-map model
module tb_data_mem_responder;

    localparam int DEPTH = 64;

    logic       CLK = 1'b0;
    logic       RESET_L;
    logic [7:0] OUT_PORT;
    logic       ERR;

    data_mem_responder_if bus ();

    data_mem_responder #(.DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RESET_L  (RESET_L),
        .bus      (bus),
        .OUT_PORT (OUT_PORT),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    logic [7:0] m_ram [256];
    logic [7:0] m_out;
    logic [7:0] m_cyc;
    logic [7:0] m_stc;
    logic       m_err;
    logic       m_wrap;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [7:0] a);
        if (int'(a) < DEPTH) return m_ram[a];
        case (a)
            8'hFC:   return m_out;
            8'hFD:   return m_cyc;
            8'hFE:   return m_stc;
            8'hFF:   return {6'b000000, m_wrap, m_err};
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_reset();
        m_out  = 8'h00;
        m_cyc  = 8'h00;
        m_stc  = 8'h00;
        m_err  = 1'b0;
        m_wrap = 1'b0;
    endfunction

    // One clock edge of the memory map, from the address-map rules.
    function automatic void model_step(input logic en_l, input logic [7:0] a,
                                       input logic [7:0] d, input logic mw);
        bit st;
        bit cyc_load;
        bit wrap_ev;
        bit err_ev;
        if (en_l) return;
        st       = mw;
        cyc_load = st && (a == 8'hFD);
        wrap_ev  = !cyc_load && (m_cyc == 8'hFF);
        err_ev   = st && (int'(a) >= DEPTH) && (int'(a) < 252);
        if (st && a == 8'hFF) begin
            if (d[0]) m_err  = 1'b0;
            if (d[1]) m_wrap = 1'b0;
        end
        if (wrap_ev) m_wrap = 1'b1;
        if (err_ev)  m_err  = 1'b1;
        m_cyc = cyc_load ? d : 8'((int'(m_cyc) + 1) % 256);
        if (st) begin
            if (a == 8'hFE)           m_stc = 8'h00;
            else if (m_stc != 8'hFF)  m_stc = m_stc + 8'd1;
        end
        if (st && int'(a) < DEPTH) m_ram[a] = d;
        if (st && a == 8'hFC)      m_out = d;
    endfunction

    always @(negedge CLK) begin
        if (check_en && RESET_L) begin
            check8("rdata",    bus.RDATA,   exp_rd(bus.ADDR));
            check8("out_port", OUT_PORT,    m_out);
            check8("err",      {7'b0, ERR}, {7'b0, m_err});
        end
    end

    task automatic cycle(input logic en_l, input logic [7:0] a, input logic [7:0] d, input logic mw);
        bus.EN_L  = en_l;
        bus.ADDR  = a;
        bus.WDATA = d;
        bus.MW    = mw;
        @(posedge CLK);
        model_step(en_l, a, d, mw);
        #1;
    endtask

    task automatic cycle_chk(input logic en_l, input logic [7:0] a, input logic [7:0] d,
                             input logic mw, input string name, input logic [7:0] exp);
        bus.EN_L  = en_l;
        bus.ADDR  = a;
        bus.WDATA = d;
        bus.MW    = mw;
        #1;
        check8(name, bus.RDATA, exp);
        @(posedge CLK);
        model_step(en_l, a, d, mw);
        #1;
    endtask

    // Reset pulse strictly between clock edges.
    task automatic async_reset_pulse();
        bus.EN_L = 1'b1;
        bus.MW   = 1'b0;
        bus.ADDR = 8'hFD;
        RESET_L  = 1'b0;
        #1;
        check8("areset_out",  OUT_PORT,    8'h00);
        check8("areset_err",  {7'b0, ERR}, 8'h00);
        check8("areset_cyc",  bus.RDATA,   8'h00);
        #1;
        RESET_L = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] d;

        RESET_L   = 1'b0;
        bus.EN_L  = 1'b1;
        bus.MW    = 1'b0;
        bus.WDATA = 8'h00;
        bus.ADDR  = 8'hFC;
        model_reset();
        #1 check8("rst_fc", bus.RDATA, 8'h00);
        bus.ADDR = 8'hFD;
        #1 check8("rst_fd", bus.RDATA, 8'h00);
        bus.ADDR = 8'hFE;
        #1 check8("rst_fe", bus.RDATA, 8'h00);
        bus.ADDR = 8'hFF;
        #1 check8("rst_ff", bus.RDATA, 8'h00);
        check8("rst_out", OUT_PORT, 8'h00);
        check8("rst_err", {7'b0, ERR}, 8'h00);
        @(posedge CLK);
        #1 RESET_L = 1'b1;
        check_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'(i), 8'($urandom), 1'b1);

        cycle(1'b0, 8'h10, 8'h33, 1'b1);
        cycle_chk(1'b0, 8'h10, 8'h5A, 1'b1, "rd_during_wr_old", 8'h33);
        cycle_chk(1'b0, 8'h10, 8'h00, 1'b0, "rd_after_wr_new", 8'h5A);
        cycle(1'b0, 8'(DEPTH - 1), 8'h77, 1'b1);
        cycle_chk(1'b0, 8'(DEPTH - 1), 8'h00, 1'b0, "ram_top", 8'h77);

        cycle(1'b0, 8'h80, 8'h11, 1'b1);
        check8("err_set", {7'b0, ERR}, 8'h01);
        cycle_chk(1'b0, 8'h80, 8'h00, 1'b0, "unmapped_rd", 8'h00);
        cycle_chk(1'b0, 8'hFE, 8'h00, 1'b0, "stc_counts_illegal", 8'(DEPTH + 4));
        cycle(1'b0, 8'hFF, 8'h01, 1'b1);
        check8("err_w1c", {7'b0, ERR}, 8'h00);

        cycle(1'b0, 8'hFD, 8'hFE, 1'b1);
        cycle_chk(1'b0, 8'hFD, 8'h00, 1'b0, "cyc_fe", 8'hFE);
        cycle_chk(1'b0, 8'hFD, 8'h00, 1'b0, "cyc_ff", 8'hFF);
        cycle_chk(1'b0, 8'hFD, 8'h00, 1'b0, "cyc_00", 8'h00);
        cycle_chk(1'b0, 8'hFF, 8'h00, 1'b0, "status_wrap", 8'h02);
        cycle(1'b0, 8'hFF, 8'h02, 1'b1);

        for (int i = 0; i < 300; i++)
            cycle(1'b0, 8'($urandom_range(8'h11, DEPTH - 2)), 8'($urandom), 1'b1);
        cycle_chk(1'b0, 8'hFE, 8'h00, 1'b0, "stc_sat", 8'hFF);
        cycle(1'b0, 8'hFE, 8'hAB, 1'b1);
        cycle_chk(1'b0, 8'hFE, 8'h00, 1'b0, "stc_clr", 8'h00);
        cycle(1'b0, 8'hFC, 8'hC3, 1'b1);

        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'h10, 8'($urandom), 1'b1);
            cycle(1'b1, 8'hFC, 8'($urandom), 1'b1);
        end
        cycle_chk(1'b1, 8'h10, 8'h00, 1'b0, "stall_ram", 8'h5A);
        cycle_chk(1'b1, 8'hFC, 8'h00, 1'b0, "stall_out", 8'hC3);
        cycle_chk(1'b1, 8'hFE, 8'h00, 1'b0, "stall_stc", 8'h01);

        cycle(1'b0, 8'h90, 8'h00, 1'b1);
        async_reset_pulse();

        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: a = 8'($urandom_range(0, DEPTH - 1));
                3:       a = 8'($urandom_range(DEPTH, 8'hFB));
                4:       a = 8'(DEPTH - 1);
                5:       a = 8'(DEPTH);
                default: a = 8'($urandom_range(8'hFC, 8'hFF));
            endcase
            d = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
            if ($urandom_range(0, 499) == 0) async_reset_pulse();
            else cycle(($urandom_range(0, 4) == 0), a, d, $urandom_range(0, 1) == 1);
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
